arcfour_prga_decrypt: RTL and testbench
=======================================

// Module: arcfour_prga_decrypt
// PURPOSE
//  RC4 keystream generator and decryptor; runs after the key-scheduling pass.
//  Reads and swaps the scheduled S-box in S RAM and generates one keystream byte per
//  message byte. XORs each with the encrypted-message ROM and writes plaintext to
//  decrypted RAM. Also reports whether the plaintext is all lowercase/space (key-search check).
// PARAMETERS
//  RAM_WIDTH   8   data/address width of S RAM (S has 2**RAM_WIDTH entries)
//  MSG_LENGTH  32  bytes in encrypted ROM / decrypted RAM; localparam MW=$clog2(MSG_LENGTH)
// PORTS
//  clk              in  1          sole clock; all state changes on posedge
//  reset            in  1          synchronous, active-low (reset==0 resets on posedge clk)
//  start_sig        in  1          begin decryption; sampled only in IDLE
//  s_ram_out        in  RAM_WIDTH  S RAM read data
//  s_address        out RAM_WIDTH  S RAM address
//  s_ram_in         out RAM_WIDTH  S RAM write data
//  s_write_enable   out 1          S RAM write strobe
//  msg_rom_out      in  8          encrypted ROM read data
//  msg_address      out MW         encrypted ROM address
//  dec_address      out MW         decrypted RAM address
//  dec_ram_in       out 8          decrypted RAM write data
//  dec_write_enable out 1          decrypted RAM write strobe
//  decrypt_finished out 1          level; high from completion until next accepted start
//  msg_valid        out 1          result flag; meaningful while decrypt_finished==1
//  state_tap        out 4          current state encoding (debug)
// BEHAVIOUR
//  - Memories: synchronous read; data valid the cycle after the address is driven.
//    Writes take effect on the edge where the write enable is high.
//  - Reset: state=IDLE; i=j=k=0; all addresses, data, write enables, decrypt_finished and
//    msg_valid=0. Reset mid-run aborts at once. S RAM is left partly swapped, not restored.
//  - State i, j, si, sj: RAM_WIDTH bits, all sums mod 2**RAM_WIDTH (wrap). k counts 0..MSG_LENGTH-1.
//  - FSM, one byte per 8 cycles:
//    IDLE: if start_sig: i<=1, j<=0, k<=0, ok<=1, decrypt_finished<=0, msg_valid<=0 -> RD_SI.
//    RD_SI:  s_address=i                                  -> GET_SI
//    GET_SI: si<=s_ram_out; j<=j+s_ram_out                -> RD_SJ
//    RD_SJ:  s_address=j                                  -> GET_SJ
//    GET_SJ: sj<=s_ram_out                                -> WR_I
//    WR_I:   s_address=i, s_ram_in=sj, s_write_enable=1   -> WR_J
//    WR_J:   s_address=j, s_ram_in=si, s_write_enable=1   -> RD_F
//    RD_F:   s_address=si+sj, msg_address=k               -> GET_F
//    GET_F:  dec_address=k, dec_ram_in=s_ram_out^msg_rom_out, dec_write_enable=1;
//            ok<=0 if byte not in {8'h20, 8'h61..8'h7A};
//            if k==MSG_LENGTH-1: decrypt_finished<=1, msg_valid<=final ok -> IDLE;
//            else: k<=k+1, i<=i+1 -> RD_SI.
//  - Write enables are high only in WR_I, WR_J and GET_F. msg_address holds k between reads.
//  - i==j: two writes of the same value; S[i] is unchanged, as RC4 requires.
//  - start_sig is ignored outside IDLE. A start in IDLE with decrypt_finished=1 restarts
//    from i=j=k=0 on the current S RAM contents.
//  - Latency: start accepted at edge E0; decrypt_finished rises at edge E0+8*MSG_LENGTH.
// TESTING
//  T1 MSG_LENGTH=2, S[x]=x, ROM={6A,6C}, start -> keystream 02,05; dec={68,69};
//     S[2]=3, S[3]=2, all other S unchanged; finished 16 edges after start; msg_valid=1.
//  T2 Same as T1 but ROM={02,05} -> dec={00,00}, msg_valid=0, decrypt_finished=1.
//  T3 start_sig held high during a run -> no restart; single completion at E0+8*MSG_LENGTH;
//     after finish, a new start clears decrypt_finished the next edge.
//  T4 reset=0 in the middle of byte 5 -> next edge IDLE; all outputs 0; then a new start
//     runs to completion normally.
//  T5 MSG_LENGTH=300, S from software KSA of key 00_03_49 -> i and j wrap past 255;
//     all dec bytes match the C model.
//  T6 Bus monitor, all runs -> at most one write enable high per cycle; S RAM stays a
//     permutation of 0..255 at finish.

Source files
------------

// File: rtl/arcfour_prga_decrypt.sv
// RC4 keystream generator / decryptor: swaps the scheduled S-box in place, XORs the
// keystream with the encrypted ROM, writes plaintext and flags all-lowercase/space text.
module arcfour_prga_decrypt #(
  parameter int RAM_WIDTH  = 8,
  parameter int MSG_LENGTH = 32,
  localparam int MW        = $clog2(MSG_LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_sig,
  input  logic [RAM_WIDTH-1:0] s_ram_out,
  output logic [RAM_WIDTH-1:0] s_address,
  output logic [RAM_WIDTH-1:0] s_ram_in,
  output logic                 s_write_enable,
  input  logic [7:0]           msg_rom_out,
  output logic [MW-1:0]        msg_address,
  output logic [MW-1:0]        dec_address,
  output logic [7:0]           dec_ram_in,
  output logic                 dec_write_enable,
  output logic                 decrypt_finished,
  output logic                 msg_valid,
  output logic [3:0]           state_tap
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_SI  = 4'd1,
    GET_SI = 4'd2,
    RD_SJ  = 4'd3,
    GET_SJ = 4'd4,
    WR_I   = 4'd5,
    WR_J   = 4'd6,
    RD_F   = 4'd7,
    GET_F  = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [RAM_WIDTH-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MW-1:0]        k_q, k_d;
  logic                 ok_q, ok_d, fin_q, fin_d, valid_q, valid_d;
  logic [7:0]           dec_byte;
  logic                 byte_ok, last_byte;

  assign dec_byte  = 8'(s_ram_out) ^ msg_rom_out;
  assign byte_ok   = (dec_byte == 8'h20) || ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A));
  assign last_byte = (k_q == MW'(MSG_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_sig) state_d = RD_SI;
      RD_SI:   state_d = GET_SI;
      GET_SI:  state_d = RD_SJ;
      RD_SJ:   state_d = GET_SJ;
      GET_SJ:  state_d = WR_I;
      WR_I:    state_d = WR_J;
      WR_J:    state_d = RD_F;
      RD_F:    state_d = GET_F;
      GET_F:   state_d = last_byte ? IDLE : RD_SI;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address        = '0;
    s_ram_in         = '0;
    s_write_enable   = 1'b0;
    dec_address      = '0;
    dec_ram_in       = '0;
    dec_write_enable = 1'b0;
    unique case (state_q)
      RD_SI: s_address = i_q;
      RD_SJ: s_address = j_q;
      WR_I: begin
        s_address      = i_q;
        s_ram_in       = sj_q;
        s_write_enable = 1'b1;
      end
      WR_J: begin
        s_address      = j_q;
        s_ram_in       = si_q;
        s_write_enable = 1'b1;
      end
      RD_F: s_address = si_q + sj_q;
      GET_F: begin
        dec_address      = k_q;
        dec_ram_in       = dec_byte;
        dec_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign msg_address      = k_q;
  assign decrypt_finished = fin_q;
  assign msg_valid        = valid_q;
  assign state_tap        = state_q;

  // i is pre-incremented on start so the first byte reads S[1], as RC4 requires.
  always_comb begin
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
    ok_d    = ok_q;
    fin_d   = fin_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: if (start_sig) begin
        i_d     = RAM_WIDTH'(1);
        j_d     = '0;
        k_d     = '0;
        ok_d    = 1'b1;
        fin_d   = 1'b0;
        valid_d = 1'b0;
      end
      GET_SI: begin
        si_d = s_ram_out;
        j_d  = j_q + s_ram_out;
      end
      GET_SJ: sj_d = s_ram_out;
      GET_F: begin
        if (!byte_ok) ok_d = 1'b0;
        if (last_byte) begin
          fin_d   = 1'b1;
          valid_d = ok_q & byte_ok;
        end else begin
          k_d = k_q + MW'(1);
          i_d = i_q + RAM_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      ok_q    <= 1'b0;
      fin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      ok_q    <= ok_d;
      fin_q   <= fin_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_arcfour_prga_decrypt.sv
// Bench for arcfour_prga_decrypt: two instances (2-byte and 300-byte messages) with
// behavioural memories, a reference RC4 model and a scoreboard of plaintext writes.
module tb_arcfour_prga_decrypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_saddr, a_sin, a_din, sa_rd, ra_rd;
  logic       a_swe, a_dwe, a_fin, a_valid;
  logic       a_maddr, a_daddr;
  logic [3:0] a_state;
  logic [7:0] b_saddr, b_sin, b_din, sb_rd, rb_rd;
  logic       b_swe, b_dwe, b_fin, b_valid;
  logic [8:0] b_maddr, b_daddr;
  logic [3:0] b_state;

  logic [7:0] sa_mem [256];
  logic [7:0] sb_mem [256];
  logic [7:0] rom_a [2];
  logic [7:0] rom_b [300];
  logic       ld_a = 1'b0, ld_b = 1'b0;
  logic [7:0] ld_addr = '0, ld_data = '0;

  arcfour_prga_decrypt #(.RAM_WIDTH(8), .MSG_LENGTH(2)) dut_a (
    .clk(clk), .reset(rst_n), .start_sig(start_a), .s_ram_out(sa_rd),
    .s_address(a_saddr), .s_ram_in(a_sin), .s_write_enable(a_swe),
    .msg_rom_out(ra_rd), .msg_address(a_maddr), .dec_address(a_daddr),
    .dec_ram_in(a_din), .dec_write_enable(a_dwe), .decrypt_finished(a_fin),
    .msg_valid(a_valid), .state_tap(a_state));

  arcfour_prga_decrypt #(.RAM_WIDTH(8), .MSG_LENGTH(300)) dut_b (
    .clk(clk), .reset(rst_n), .start_sig(start_b), .s_ram_out(sb_rd),
    .s_address(b_saddr), .s_ram_in(b_sin), .s_write_enable(b_swe),
    .msg_rom_out(rb_rd), .msg_address(b_maddr), .dec_address(b_daddr),
    .dec_ram_in(b_din), .dec_write_enable(b_dwe), .decrypt_finished(b_fin),
    .msg_valid(b_valid), .state_tap(b_state));

  always @(posedge clk) begin
    if (ld_a) sa_mem[ld_addr] <= ld_data;
    else if (a_swe) sa_mem[a_saddr] <= a_sin;
    sa_rd <= sa_mem[a_saddr];
    ra_rd <= rom_a[a_maddr];
    if (ld_b) sb_mem[ld_addr] <= ld_data;
    else if (b_swe) sb_mem[b_saddr] <= b_sin;
    sb_rd <= sb_mem[b_saddr];
    rb_rd <= rom_b[b_maddr];
  end

  typedef struct {int addr; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  logic [7:0] ms [256];
  int errors = 0;
  int checks = 0;

  function automatic bit is_text(input logic [7:0] p);
    return (p == 8'h20) || (p >= 8'h61 && p <= 8'h7a);
  endfunction

  task automatic model_identity();
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
  endtask

  task automatic model_ksa();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key = '{8'h00, 8'h03, 8'h49};
    model_identity();
    j = 8'h00;
    for (int x = 0; x < 256; x++) begin
      j = j + ms[x] + key[x % 3];
      t = ms[x]; ms[x] = ms[j]; ms[j] = t;
    end
  endtask

  // Reference RC4 PRGA on ms; pushes expected plaintext and returns the text flag.
  task automatic model_run(input int n, input bit use_b, output bit valid);
    logic [7:0] i, j, t, ks, p;
    i = 8'h00; j = 8'h00; valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      i = i + 8'h01;
      j = j + ms[i];
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      t = ms[i] + ms[j];
      ks = ms[t];
      p = ks ^ (use_b ? rom_b[k] : rom_a[k]);
      exp_q.push_back('{k, p});
      if (!is_text(p)) valid = 1'b0;
    end
  endtask

  task automatic gen_rom_b(input bit text);
    logic [7:0] s [256];
    logic [7:0] i, j, t, c;
    int r;
    s = ms; i = 8'h00; j = 8'h00;
    for (int k = 0; k < 300; k++) begin
      i = i + 8'h01;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      r = $urandom_range(26, 0);
      c = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      rom_b[k] = text ? (s[t] ^ c) : 8'($urandom);
    end
  endtask

  task automatic load_s(input bit sel);
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_a = !sel; ld_b = sel; ld_addr = 8'(a); ld_data = ms[a];
    end
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  // Advances to the next negedge each step, consuming scoreboard entries and
  // checking write-enable exclusivity, until finish or the step budget runs out.
  task automatic wait_a(input bit hold, input int stop, output int cnt);
    exp_t e;
    cnt = 0;
    while (cnt < stop) begin
      @(negedge clk); cnt++;
      if (!hold) start_a = 1'b0;
      if (a_swe || a_dwe) begin
        checks++;
        if (a_swe && a_dwe) begin
          errors++; $display("FAIL a_we_excl: both write enables high at %0t", $time);
        end
      end
      if (a_dwe) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL a_sb_extra: write addr=%0d data=%02h, none expected", a_daddr, a_din);
        end else begin
          e = exp_q.pop_front();
          if (int'(a_daddr) != e.addr || a_din !== e.data) begin
            errors++;
            $display("FAIL a_sb_data: got addr=%0d data=%02h, want addr=%0d data=%02h", a_daddr, a_din, e.addr, e.data);
          end
        end
      end
      if (a_fin) break;
    end
  endtask

  task automatic wait_b(input int stop, output int cnt);
    exp_t e;
    cnt = 0;
    while (cnt < stop) begin
      @(negedge clk); cnt++;
      start_b = 1'b0;
      if (b_swe || b_dwe) begin
        checks++;
        if (b_swe && b_dwe) begin
          errors++; $display("FAIL b_we_excl: both write enables high at %0t", $time);
        end
      end
      if (b_dwe) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b_sb_extra: write addr=%0d data=%02h, none expected", b_daddr, b_din);
        end else begin
          e = exp_q.pop_front();
          if (int'(b_daddr) != e.addr || b_din !== e.data) begin
            errors++;
            $display("FAIL b_sb_data: got addr=%0d data=%02h, want addr=%0d data=%02h", b_daddr, b_din, e.addr, e.data);
          end
        end
      end
      if (b_fin) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_saddr, a_sin, a_swe, a_maddr, a_daddr, a_din, a_dwe, a_fin, a_valid, a_state} !== '0) begin
      errors++; $display("FAIL reset_a: state=%0d fin=%b valid=%b, want all outputs 0", a_state, a_fin, a_valid);
    end
    checks++;
    if ({b_saddr, b_sin, b_swe, b_maddr, b_daddr, b_din, b_dwe, b_fin, b_valid, b_state} !== '0) begin
      errors++; $display("FAIL reset_b: state=%0d fin=%b valid=%b, want all outputs 0", b_state, b_fin, b_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit v; int cnt, bad;
    model_identity(); load_s(1'b0);
    rom_a[0] = 8'h6A; rom_a[1] = 8'h6C;
    model_run(2, 1'b0, v);
    @(negedge clk); start_a = 1'b1;
    wait_a(1'b0, 40, cnt);
    checks++;
    if (cnt != 17 || a_fin !== 1'b1) begin
      errors++; $display("FAIL basic_latency: finished after %0d negedges fin=%b, want 17 fin=1", cnt, a_fin);
    end
    checks++;
    if (a_valid !== v) begin
      errors++; $display("FAIL basic_valid: got %b want %b", a_valid, v);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_count: %0d writes missing", exp_q.size());
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (sa_mem[x] !== ms[x]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_sbox: %0d entries differ, want 0 (S[2]=%02h S[3]=%02h)", bad, sa_mem[2], sa_mem[3]);
    end
  endtask

  task automatic test_invalid_text();
    bit v; int cnt;
    model_identity(); load_s(1'b0);
    rom_a[0] = 8'h02; rom_a[1] = 8'h05;
    model_run(2, 1'b0, v);
    @(negedge clk); start_a = 1'b1;
    wait_a(1'b0, 40, cnt);
    checks++;
    if (a_fin !== 1'b1 || a_valid !== 1'b0 || v) begin
      errors++; $display("FAIL invalid_flag: fin=%b valid=%b, want fin=1 valid=0", a_fin, a_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL invalid_count: %0d writes missing", exp_q.size());
    end
  endtask

  task automatic test_start_held();
    bit v; int cnt;
    model_identity(); load_s(1'b0);
    rom_a[0] = 8'h6A; rom_a[1] = 8'h6C;
    model_run(2, 1'b0, v);
    @(negedge clk); start_a = 1'b1;
    wait_a(1'b1, 40, cnt);
    checks++;
    if (cnt != 17 || a_fin !== 1'b1) begin
      errors++; $display("FAIL held_latency: finished after %0d negedges fin=%b, want 17 fin=1", cnt, a_fin);
    end
    model_run(2, 1'b0, v);
    @(negedge clk);
    checks++;
    if (a_fin !== 1'b0 || a_state !== 4'd1) begin
      errors++; $display("FAIL held_restart: fin=%b state=%0d, want fin=0 state=1", a_fin, a_state);
    end
    start_a = 1'b0;
    wait_a(1'b0, 40, cnt);
    checks++;
    if (cnt != 16 || a_fin !== 1'b1 || a_valid !== v) begin
      errors++; $display("FAIL held_second: cnt=%0d fin=%b valid=%b, want 16 1 %b", cnt, a_fin, a_valid, v);
    end
  endtask

  task automatic test_wrap_ksa();
    bit v; int cnt, bad;
    bit seen [256];
    model_ksa(); load_s(1'b1);
    gen_rom_b(1'b1);
    model_run(300, 1'b1, v);
    @(negedge clk); start_b = 1'b1;
    wait_b(2500, cnt);
    checks++;
    if (cnt != 2401 || b_fin !== 1'b1 || b_valid !== v || !v) begin
      errors++; $display("FAIL wrap_done: cnt=%0d fin=%b valid=%b, want 2401 1 1", cnt, b_fin, b_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_count: %0d writes missing", exp_q.size());
    end
    bad = 0;
    for (int x = 0; x < 256; x++) seen[x] = 1'b0;
    for (int x = 0; x < 256; x++) begin
      if (^sb_mem[x] === 1'bx || seen[sb_mem[x]]) bad++;
      else seen[sb_mem[x]] = 1'b1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_perm: %0d duplicate/unknown S entries, want 0", bad);
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (sb_mem[x] !== ms[x]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_sbox: %0d entries differ from model, want 0", bad);
    end
  endtask

  task automatic test_reset_midrun();
    bit v; int cnt;
    model_identity(); load_s(1'b1);
    gen_rom_b(1'b0);
    model_run(300, 1'b1, v);
    @(negedge clk); start_b = 1'b1;
    wait_b(42, cnt);
    checks++;
    if (b_state !== 4'd2 || exp_q.size() != 295) begin
      errors++; $display("FAIL abort_pos: state=%0d pending=%0d, want state=2 pending=295", b_state, exp_q.size());
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_saddr, b_sin, b_swe, b_maddr, b_daddr, b_din, b_dwe, b_fin, b_valid, b_state} !== '0) begin
      errors++; $display("FAIL abort_outputs: state=%0d maddr=%0d fin=%b, want all 0", b_state, b_maddr, b_fin);
    end
    rst_n = 1'b1;
    exp_q.delete();
    model_identity(); load_s(1'b1);
    model_run(300, 1'b1, v);
    @(negedge clk); start_b = 1'b1;
    wait_b(2500, cnt);
    checks++;
    if (cnt != 2401 || b_fin !== 1'b1 || b_valid !== v) begin
      errors++; $display("FAIL abort_rerun: cnt=%0d fin=%b valid=%b, want 2401 1 %b", cnt, b_fin, b_valid, v);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL abort_count: %0d writes missing", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid_text();
    test_start_held();
    test_wrap_ksa();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
